stage5_fence_controller: RTL and testbench

- Sequences the cache and TLB maintenance required by FENCE.I and SFENCE.VMA in the five-stage pipeline.
- Sits between the memory-stage fence decode and the cache/TLB flush handshakes.
- Drives fence_stall to the stage5 hazard unit, which stalls E/M while fence_stall=1 and raises rollback on the first cycle fence_stall=0 with the fence still present.
- Also provides a per-step watchdog and a completed-fence counter.

---
 rtl/stage5_fence_controller.sv | 83 ++++++++
 tb/tb_stage5_fence_controller.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/stage5_fence_controller.sv
// stage5_fence_controller: sequences D$ write-back, I$ invalidation and TLB flush for FENCE.I / SFENCE.VMA.
// Ports:
//   CLK, nRST                  clock (rising edge), asynchronous active-low reset
//   ifence, sfence             fence present in memory stage (levels)
//   dflush_req / dflush_done   D$ write-back handshake
//   iclear_req / iclear_done   I$ invalidate handshake
//   tlb_flush_req / itlb_flush_done, dtlb_flush_done   ITLB+DTLB flush handshake
//   fence_stall                stall request to the hazard unit
//   fence_timeout              one-cycle pulse when the watchdog forces a step forward
//   fence_count                completed fence sequences (wraps)
module stage5_fence_controller #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ifence,
  input  logic             sfence,
  output logic             dflush_req,
  input  logic             dflush_done,
  output logic             iclear_req,
  input  logic             iclear_done,
  output logic             tlb_flush_req,
  input  logic             itlb_flush_done,
  input  logic             dtlb_flush_done,
  output logic             fence_stall,
  output logic             fence_timeout,
  output logic [CNT_W-1:0] fence_count
);
  typedef enum logic [2:0] {IDLE, DFLUSH, ICLEAR, TLBFLUSH, DONE} state_t;
  localparam int WD_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  state_t state, next;
  logic [WD_W-1:0] wd;
  logic do_cache, do_tlb, it_s, dt_s, hs, tlb_both, step_done, adv;
  // a TLB done arriving in the same cycle as the check counts as seen
  always_comb begin
    tlb_both = (it_s | itlb_flush_done) & (dt_s | dtlb_flush_done);
    hs = state == DFLUSH || state == ICLEAR || state == TLBFLUSH;
    step_done = state == DFLUSH ? dflush_done :
                state == ICLEAR ? iclear_done :
                state == TLBFLUSH ? tlb_both : 1'b0;
    fence_timeout = TIMEOUT_CYCLES != 0 && hs && wd == WD_MAX && !step_done;
    adv = step_done | fence_timeout;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = ifence ? DFLUSH : sfence ? TLBFLUSH : IDLE;
      DFLUSH:   next = adv ? (do_cache ? ICLEAR : DONE) : DFLUSH;
      ICLEAR:   next = adv ? (do_tlb ? TLBFLUSH : DONE) : ICLEAR;
      TLBFLUSH: next = adv ? DONE : TLBFLUSH;
      DONE:     next = (ifence | sfence) ? DONE : IDLE;
      default:  next = IDLE;
    endcase
  end
  // DONE releases the stall so the hazard unit can roll back while the fence is still present
  always_comb fence_stall = (ifence | sfence) && state != DONE;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      dflush_req <= 1'b0;
      iclear_req <= 1'b0;
      tlb_flush_req <= 1'b0;
      wd <= '0;
      do_cache <= 1'b0;
      do_tlb <= 1'b0;
      it_s <= 1'b0;
      dt_s <= 1'b0;
      fence_count <= '0;
    end else begin
      state <= next;
      dflush_req <= next == DFLUSH;
      iclear_req <= next == ICLEAR;
      tlb_flush_req <= next == TLBFLUSH;
      wd <= (state != next || !hs) ? '0 : wd + 1'b1;
      if (state == IDLE && next != IDLE) {do_cache, do_tlb} <= {ifence, sfence};
      it_s <= state == TLBFLUSH && next == TLBFLUSH && (it_s | itlb_flush_done);
      dt_s <= state == TLBFLUSH && next == TLBFLUSH && (dt_s | dtlb_flush_done);
      if (next == DONE && state != DONE) fence_count <= fence_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_stage5_fence_controller.sv
// tb_stage5_fence_controller: randomized and directed stimulus against a step-queue reference model.
module tb_stage5_fence_controller;
  localparam int T = 8;
  localparam int CW = 4;
  logic CLK = 0, nRST = 0, ifence = 0, sfence = 0;
  logic dflush_done = 0, iclear_done = 0, itlb_flush_done = 0, dtlb_flush_done = 0;
  logic dflush_req, iclear_req, tlb_flush_req, fence_stall, fence_timeout;
  logic [CW-1:0] fence_count;
  stage5_fence_controller #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .ifence(ifence), .sfence(sfence),
    .dflush_req(dflush_req), .dflush_done(dflush_done),
    .iclear_req(iclear_req), .iclear_done(iclear_done),
    .tlb_flush_req(tlb_flush_req), .itlb_flush_done(itlb_flush_done),
    .dtlb_flush_done(dtlb_flush_done), .fence_stall(fence_stall),
    .fence_timeout(fence_timeout), .fence_count(fence_count)
  );
  always #5 CLK = ~CLK;
  typedef struct packed {
    logic d, i, t, st, to;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  // reference model: pending maintenance steps (1=D$ flush, 2=I$ clear, 3=TLB flush)
  int steps[$];
  bit in_done, it_seen, dt_seen;
  int age;
  logic [CW-1:0] mcount;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic mreset();
    steps.delete();
    in_done = 0;
    it_seen = 0;
    dt_seen = 0;
    age = 0;
    mcount = '0;
  endtask
  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("dflush_req", dflush_req, e.d);
      chk("iclear_req", iclear_req, e.i);
      chk("tlb_flush_req", tlb_flush_req, e.t);
      chk("fence_stall", fence_stall, e.st);
      chk("fence_timeout", fence_timeout, e.to);
      chk("fence_count", fence_count, e.cnt);
    end
  end
  task automatic cyc(input bit fi, input bit fs, input bit dd, input bit icd, input bit itd, input bit dtd);
    int cur;
    bit sd, to;
    exp_t e;
    @(posedge CLK);
    #1;
    ifence = fi; sfence = fs;
    dflush_done = dd; iclear_done = icd; itlb_flush_done = itd; dtlb_flush_done = dtd;
    cur = steps.size() != 0 ? steps[0] : 0;
    sd = cur == 1 ? dd : cur == 2 ? icd : cur == 3 ? ((it_seen | itd) & (dt_seen | dtd)) : 1'b0;
    to = cur != 0 && age == T - 1 && !sd;
    e.d = cur == 1; e.i = cur == 2; e.t = cur == 3;
    e.st = (fi | fs) && !in_done; e.to = to; e.cnt = mcount;
    q.push_back(e);
    if (in_done) begin
      if (!(fi | fs)) in_done = 0;
    end else if (cur == 0) begin
      if (fi) begin steps.push_back(1); steps.push_back(2); end
      if (fs) steps.push_back(3);
      age = 0;
    end else if (sd || to) begin
      void'(steps.pop_front());
      age = 0; it_seen = 0; dt_seen = 0;
      if (steps.size() == 0) begin in_done = 1; mcount++; end
    end else begin
      age++;
      if (cur == 3) begin it_seen |= itd; dt_seen |= dtd; end
    end
  endtask
  task automatic hit_reset();
    @(negedge CLK);
    #1;
    nRST = 0;
    ifence = 0; sfence = 0;
    dflush_done = 0; iclear_done = 0; itlb_flush_done = 0; dtlb_flush_done = 0;
    #1;
    chk("rst_dflush_req", dflush_req, 0);
    chk("rst_iclear_req", iclear_req, 0);
    chk("rst_tlb_flush_req", tlb_flush_req, 0);
    chk("rst_fence_count", fence_count, 0);
    mreset();
    @(posedge CLK);
    @(negedge CLK);
    #1;
    nRST = 1;
  endtask
  initial begin
    bit rfi, rfs;
    mreset();
    #1;
    chk("reset_dflush_req", dflush_req, 0);
    chk("reset_iclear_req", iclear_req, 0);
    chk("reset_tlb_flush_req", tlb_flush_req, 0);
    chk("reset_fence_stall", fence_stall, 0);
    chk("reset_fence_timeout", fence_timeout, 0);
    chk("reset_fence_count", fence_count, 0);
    #11 nRST = 1;
    for (int i = 0; i < 12; i++) cyc(1, 0, i == 5, i == 9, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, i == 3, i == 6);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, i == 2, i == 4, i == 7, i == 7);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, i == 12, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(i < 2, 0, i == 4, i == 6, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) cyc(i != 5, 0, i == 2 || i == 8, i == 3 || i == 10, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, i == 1, 0, 0, 0);
    hit_reset();
    rfi = 0;
    rfs = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        rfi = 1'($urandom_range(0, 1));
        rfs = 1'($urandom_range(0, 1));
      end
      cyc(rfi, rfs, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 599) == 0) hit_reset();
    end
    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
